// File: rtl/stump_pkg.sv
// Shared Stump definitions: ALU function codes, opcodes, condition codes and
// control-FSM state encodings.
package stump_pkg;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_ADC = 3'b001,
        FN_SUB = 3'b010,
        FN_SBC = 3'b011,
        FN_AND = 3'b100,
        FN_OR  = 3'b101,
        FN_RS6 = 3'b110,
        FN_RS7 = 3'b111
    } alu_fn_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SBC  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_LDST = 3'b110,
        OP_BCC  = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,  CC_NV = 4'd1,  CC_HI = 4'd2,  CC_LS = 4'd3,
        CC_CC = 4'd4,  CC_CS = 4'd5,  CC_NE = 4'd6,  CC_EQ = 4'd7,
        CC_VC = 4'd8,  CC_VS = 4'd9,  CC_PL = 4'd10, CC_MI = 4'd11,
        CC_GE = 4'd12, CC_LT = 4'd13, CC_GT = 4'd14, CC_LE = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluation against condition codes {N,Z,V,C}.
module stump_cond_eval
    import stump_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n, z, v, c;

    assign n = cc[3];
    assign z = cc[2];
    assign v = cc[1];
    assign c = cc[0];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
            CC_HI: taken = ~c & ~z;
            CC_LS: taken = c | z;
            CC_CC: taken = ~c;
            CC_CS: taken = c;
            CC_NE: taken = ~z;
            CC_EQ: taken = z;
            CC_VC: taken = ~v;
            CC_VS: taken = v;
            CC_PL: taken = ~n;
            CC_MI: taken = n;
            CC_GE: taken = (n == v);
            CC_LT: taken = (n != v);
            CC_GT: taken = ~z & (n == v);
            CC_LE: taken = z | (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer, instruction decode and
// condition-code register.
module stump_control
    import stump_pkg::*;
#(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    input  logic [3:0]  flags_in,
    output logic        fetch,
    output logic        execute,
    output logic        memory,
    output logic [15:0] ir,
    output logic [2:0]  func,
    output logic        imm_sel,
    output logic [15:0] imm,
    output logic [1:0]  shift_op,
    output logic [3:0]  cc,
    output logic        pc_inc,
    output logic        reg_write,
    output logic [2:0]  dest,
    output logic        mem_ren,
    output logic        mem_wen
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  cc_q, cc_d;

    logic [2:0]  op;
    logic        op_type;
    logic        s_bit;
    logic        taken;

    assign op      = ir_q[15:13];
    assign op_type = ir_q[12];
    assign s_bit   = ir_q[11];

    stump_cond_eval u_cond (
        .cond  (ir_q[11:8]),
        .cc    (cc_q),
        .taken (taken)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cc_d    = cc_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = mem_rdata;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu_op(op) && s_bit) cc_d = flags_in;
                state_d = (op == OP_LDST) ? ST_MEMORY : ST_FETCH;
            end
            ST_MEMORY: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= IR_RESET;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cc_q    <= cc_d;
        end
    end

    assign fetch    = (state_q == ST_FETCH);
    assign execute  = (state_q == ST_EXECUTE);
    assign memory   = (state_q == ST_MEMORY);
    assign ir       = ir_q;
    assign cc       = cc_q;
    assign imm_sel  = op_type | (op == OP_BCC);
    assign imm      = (op == OP_BCC) ? {{8{ir_q[7]}}, ir_q[7:0]} : {{11{ir_q[4]}}, ir_q[4:0]};
    assign shift_op = op_type ? 2'b00 : ir_q[1:0];
    assign func     = (execute && is_alu_op(op)) ? op : FN_ADD;
    assign dest     = (execute && op == OP_BCC) ? 3'd7 : ir_q[10:8];

    // Strobes are gated by rst_n so nothing fires while reset is held,
    // even when the state register still shows MEMORY.
    always_comb begin
        pc_inc    = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        reg_write = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    pc_inc  = 1'b1;
                    mem_ren = 1'b1;
                end
                ST_EXECUTE: begin
                    if (is_alu_op(op))    reg_write = 1'b1;
                    else if (op == OP_BCC) reg_write = taken;
                end
                ST_MEMORY: begin
                    if (s_bit) mem_wen = 1'b1;
                    else begin
                        mem_ren   = 1'b1;
                        reg_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
